// File: rtl/bpu_gshare_ras.sv
// -----------------------------------------------------------------------------
// bpu_gshare_ras
//   Fetch-stage branch predictor with three parts:
//     - gshare direction predictor: a PHT of 2-bit saturating counters indexed
//       by fetch PC XOR global history (GHR).
//     - tagged, direct-mapped BTB. Each entry holds a target and a branch type
//       (COND / JUMP / RET).
//     - return-address stack (RAS). A RET-type BTB hit takes its target from
//       the RAS while the RAS holds entries.
//   Lookup is purely combinational on f_pc. All state changes are
//   non-speculative and come from the EX resolution port.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   f_pc               fetch PC to predict for
//   f_pred_taken       predicted redirect for f_pc
//   f_pred_target      predicted next PC (0 on BTB miss)
//   f_pht_idx          PHT index used for f_pc; travels down the pipe
//   f_btb_hit          BTB valid and tag match for f_pc
//   ex_update_en       a control-flow instruction resolved in EX this cycle
//   ex_pc              PC of the resolved instruction
//   ex_pht_idx         PHT index captured at fetch, used verbatim
//   ex_actual_taken    resolved direction (1 for JAL/JALR)
//   ex_actual_target   resolved target
//   ex_is_cond         conditional branch
//   ex_is_call         call (pushes ex_pc+4 onto the RAS)
//   ex_is_ret          return (pops the RAS)
//   ras_empty          RAS holds no entries
//
// Parameter legality: 1 <= GHR_W <= PHT_IDX_W, and RAS_DEPTH is a power of
// two >= 2 (the RAS pointer wraps by plain binary overflow).
// -----------------------------------------------------------------------------
module bpu_gshare_ras #(
  parameter int XLEN      = 32,
  parameter int PHT_IDX_W = 8,
  parameter int GHR_W     = 8,
  parameter int BTB_IDX_W = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      f_pc,
  output logic                 f_pred_taken,
  output logic [XLEN-1:0]      f_pred_target,
  output logic [PHT_IDX_W-1:0] f_pht_idx,
  output logic                 f_btb_hit,
  input  logic                 ex_update_en,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [PHT_IDX_W-1:0] ex_pht_idx,
  input  logic                 ex_actual_taken,
  input  logic [XLEN-1:0]      ex_actual_target,
  input  logic                 ex_is_cond,
  input  logic                 ex_is_call,
  input  logic                 ex_is_ret,
  output logic                 ras_empty
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_W;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W       = XLEN - BTB_IDX_W - 2;
  localparam int RAS_PTR_W   = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W   = $clog2(RAS_DEPTH) + 1;

  localparam logic [RAS_CNT_W-1:0] RAS_FULL = RAS_CNT_W'(RAS_DEPTH);

  // BTB entry types
  localparam logic [1:0] BTB_COND = 2'd0;
  localparam logic [1:0] BTB_JUMP = 2'd1;
  localparam logic [1:0] BTB_RET  = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]           pht        [PHT_ENTRIES];
  logic [GHR_W-1:0]     ghr;

  logic                 btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]     btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]      btb_target [BTB_ENTRIES];
  logic [1:0]           btb_type   [BTB_ENTRIES];

  logic [XLEN-1:0]      ras_mem    [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ras_ptr;   // next free slot; top of stack is ras_ptr-1
  logic [RAS_CNT_W-1:0] ras_cnt;

  // ---------------------------------------------------------------------------
  // Fetch-side lookup
  // ---------------------------------------------------------------------------
  logic [PHT_IDX_W-1:0] ghr_ext;
  logic [BTB_IDX_W-1:0] f_btb_idx;
  logic [TAG_W-1:0]     f_tag;
  logic [RAS_PTR_W-1:0] ras_top_ptr;

  // History sits in the low bits of the index; the upper bits stay zero when
  // GHR_W < PHT_IDX_W.
  always_comb begin
    ghr_ext            = '0;
    ghr_ext[GHR_W-1:0] = ghr;
  end

  assign f_pht_idx   = f_pc[PHT_IDX_W+1:2] ^ ghr_ext;
  assign f_btb_idx   = f_pc[BTB_IDX_W+1:2];
  assign f_tag       = f_pc[XLEN-1:BTB_IDX_W+2];
  assign f_btb_hit   = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
  assign ras_empty   = (ras_cnt == '0);
  assign ras_top_ptr = ras_ptr - RAS_PTR_W'(1);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path through the block can leave it unassigned and infer a latch.
    f_pred_taken  = 1'b0;
    f_pred_target = '0;
    if (f_btb_hit) begin
      f_pred_target = btb_target[f_btb_idx];
      case (btb_type[f_btb_idx])
        BTB_JUMP: f_pred_taken = 1'b1;
        BTB_COND: f_pred_taken = pht[f_pht_idx][1];
        BTB_RET: begin
          f_pred_taken = 1'b1;
          // With an empty RAS, fall back to the last target seen for this RET.
          if (!ras_empty) f_pred_target = ras_mem[ras_top_ptr];
        end
        default: f_pred_taken = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // EX-side next-state logic
  // ---------------------------------------------------------------------------
  logic [BTB_IDX_W-1:0] ex_btb_idx;
  logic [TAG_W-1:0]     ex_tag;
  logic [1:0]           ex_type;
  logic [1:0]           pht_cur;
  logic [1:0]           pht_next;
  logic [GHR_W:0]       ghr_shift;

  assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
  assign ex_tag     = ex_pc[XLEN-1:BTB_IDX_W+2];
  assign ex_type    = ex_is_ret ? BTB_RET : (ex_is_cond ? BTB_COND : BTB_JUMP);

  // Shifting through a one-bit-wider vector handles GHR_W == 1 without a
  // special case: the low GHR_W bits are the new history.
  assign ghr_shift  = {ghr, ex_actual_taken};

  assign pht_cur    = pht[ex_pht_idx];
  always_comb begin
    if (ex_actual_taken) pht_next = (pht_cur == 2'd3) ? 2'd3 : pht_cur + 2'd1;
    else                 pht_next = (pht_cur == 2'd0) ? 2'd0 : pht_cur - 2'd1;
  end

  // RAS: pop first, then push, so a coroutine JALR replaces the top entry.
  logic                 ras_pop;
  logic [RAS_PTR_W-1:0] ras_ptr_popped;
  logic [RAS_CNT_W-1:0] ras_cnt_popped;
  logic [RAS_PTR_W-1:0] ras_ptr_next;
  logic [RAS_CNT_W-1:0] ras_cnt_next;

  always_comb begin
    ras_pop        = ex_is_ret && !ras_empty;
    ras_ptr_popped = ras_pop ? ras_ptr - RAS_PTR_W'(1) : ras_ptr;
    ras_cnt_popped = ras_pop ? ras_cnt - RAS_CNT_W'(1) : ras_cnt;
    ras_ptr_next   = ras_ptr_popped;
    ras_cnt_next   = ras_cnt_popped;
    if (ex_is_call) begin
      // On overflow the pointer keeps wrapping and the oldest entry is lost.
      ras_ptr_next = ras_ptr_popped + RAS_PTR_W'(1);
      ras_cnt_next = (ras_cnt_popped == RAS_FULL) ? RAS_FULL
                                                  : ras_cnt_popped + RAS_CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments only, so every
  // register updates from pre-edge values; this is also why a lookup in the
  // update cycle sees the old contents (no bypass).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
      ghr     <= '0;
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ex_update_en) begin
      if (ex_is_cond) begin
        pht[ex_pht_idx] <= pht_next;
        ghr             <= ghr_shift[GHR_W-1:0];
      end
      if (ex_actual_taken) btb_valid[ex_btb_idx] <= 1'b1;
      ras_ptr <= ras_ptr_next;
      ras_cnt <= ras_cnt_next;
    end
  end

  // NOTE: only the valid bits are reset. Tag/target/type and the RAS slots are
  // never observed until a valid bit or the RAS count says they were written,
  // so they stay reset-free storage.
  always_ff @(posedge clk) begin
    if (ex_update_en && ex_actual_taken) begin
      btb_tag[ex_btb_idx]    <= ex_tag;
      btb_target[ex_btb_idx] <= ex_actual_target;
      btb_type[ex_btb_idx]   <= ex_type;
    end
    if (ex_update_en && ex_is_call) ras_mem[ras_ptr_popped] <= ex_pc + XLEN'(4);
  end

  // Instructions are word aligned: f_pc[1:0] carries no prediction information.
  logic unused_ok;
  assign unused_ok = ^{f_pc[1:0], ghr_shift[GHR_W]};

endmodule
